// File: rtl/mipi_tx_pkg.sv
// ----------------------------------------------------------------------------
// mipi_tx_pkg
// Shared definitions for the MIPI CSI single-lane HS byte transmitter and its
// matching byte-alignment receiver: FSM state encoding and the fixed line
// bytes (SoT sync byte, HS-zero byte).
// ----------------------------------------------------------------------------
package mipi_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEADER,
      ST_SOT,
      ST_PAYLOAD,
      ST_TRAIL,
      ST_GAP
   } tx_state_e;

   // Sync byte that opens every HS burst; the receiver hunts for this pattern.
   localparam logic [7:0] MIPI_SOT_BYTE = 8'hB8;

   // HS-zero leader byte and idle line value.
   localparam logic [7:0] MIPI_HS_ZERO  = 8'h00;

endpackage : mipi_tx_pkg

// File: rtl/mipi_bit_skew.sv
// ----------------------------------------------------------------------------
// mipi_bit_skew
// Static lane bit-misalignment emulator. Keeps the previous byte and presents,
// one clock later, the byte-wide slice of the 16-bit window {current, previous}
// starting BIT_SKEW bits below the current byte. BIT_SKEW=0 passes the stream
// through with one register of latency. Reusable in receiver testbenches.
//
// Ports:
//   I_CLK   in   1  byte clock
//   I_Rst   in   1  asynchronous active-high reset
//   I_Data  in   8  raw byte stream (LSB is the earliest bit on the wire)
//   O_Data  out  8  skewed byte stream, registered
// ----------------------------------------------------------------------------
module mipi_bit_skew #(
   parameter int unsigned BIT_SKEW = 0   // legal 0..7
) (
   input  logic       I_CLK,
   input  logic       I_Rst,
   input  logic [7:0] I_Data,
   output logic [7:0] O_Data
);

   logic [7:0] prev_q, prev_d;
   logic [7:0] data_q, data_d;

   assign prev_d = I_Data;

   // Shifting the whole window right keeps BIT_SKEW older bits from the
   // previous byte in the low end of the output, as a late-sampling lane would.
   assign data_d = 8'({I_Data, prev_q} >> (8 - BIT_SKEW));

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge value of its inputs regardless of statement order.
   // NOTE: there is no memory array here; only control/data flops, all of
   // which are cleared so the first burst after reset sees a zero history.
   always_ff @(posedge I_CLK or posedge I_Rst) begin
      if (I_Rst) begin
         prev_q <= 8'h00;
         data_q <= 8'h00;
      end else begin
         prev_q <= prev_d;
         data_q <= data_d;
      end
   end

   assign O_Data = data_q;

endmodule : mipi_bit_skew

// File: rtl/mipi_csi_byte_lane_tx.sv
// ----------------------------------------------------------------------------
// mipi_csi_byte_lane_tx
// Single-lane MIPI D-PHY HS byte-stream generator. Wraps each payload packet
// as HS-zero leader, SoT sync byte, payload and a trailer of the inverted last
// payload bit 7, one byte per clock, then forces one HS-low GAP cycle.
//
// Ports:
//   I_CLK             in   1  byte clock
//   I_Rst             in   1  asynchronous active-high reset
//   I_Tx_Data         in   8  payload byte, LSB transmitted first
//   I_Tx_Valid        in   1  payload byte valid / packet request
//   I_Tx_Last         in   1  final payload byte of the packet
//   O_Tx_Ready        out  1  byte accepted when high with I_Tx_Valid
//   O_Mipi_Byte_Data  out  8  lane byte to the serializer (skewed, registered)
//   O_Mipi_HS_En      out  1  HS burst active, aligned with the byte data
//   O_Busy            out  1  FSM was not IDLE on the previous cycle
//   O_Underflow       out  1  one-cycle pulse, payload starved mid-packet
// ----------------------------------------------------------------------------
module mipi_csi_byte_lane_tx
   import mipi_tx_pkg::*;
#(
   parameter int unsigned LEADER_LEN = 4,              // legal 1..255
   parameter int unsigned TRAIL_LEN  = 4,              // legal 1..255
   parameter logic [7:0]  SOT_BYTE   = MIPI_SOT_BYTE,
   parameter int unsigned BIT_SKEW   = 0               // legal 0..7
) (
   input  logic       I_CLK,
   input  logic       I_Rst,
   input  logic [7:0] I_Tx_Data,
   input  logic       I_Tx_Valid,
   input  logic       I_Tx_Last,
   output logic       O_Tx_Ready,
   output logic [7:0] O_Mipi_Byte_Data,
   output logic       O_Mipi_HS_En,
   output logic       O_Busy,
   output logic       O_Underflow
);

   localparam logic [7:0] LEADER_INIT   = 8'(LEADER_LEN - 1);
   localparam logic [7:0] TRAIL_INIT    = 8'(TRAIL_LEN - 1);
   // The underflow cycle already emits trailer byte 1.
   localparam logic [7:0] TRAIL_UF_INIT = 8'(TRAIL_LEN - 2);

   tx_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] last_byte_q, last_byte_d;
   logic       hs_en_q, hs_en_d;
   logic       underflow_q, underflow_d;
   logic       busy_q, busy_d;

   logic [7:0] raw_byte;
   logic       raw_hs;
   logic       tx_ready;
   logic [7:0] trail_byte;

   // Trailer drives the opposite of the final payload bit so the line toggles.
   assign trail_byte = {8{~last_byte_q[7]}};

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_byte_d = last_byte_q;
      raw_byte    = MIPI_HS_ZERO;
      raw_hs      = 1'b0;
      underflow_d = 1'b0;
      tx_ready    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (I_Tx_Valid) begin
               state_d = ST_LEADER;
               cnt_d   = LEADER_INIT;
            end
         end

         ST_LEADER: begin
            raw_hs = 1'b1;
            if (cnt_q == 8'd0) state_d = ST_SOT;
            else               cnt_d   = cnt_q - 8'd1;
         end

         ST_SOT: begin
            raw_byte = SOT_BYTE;
            raw_hs   = 1'b1;
            state_d  = ST_PAYLOAD;
         end

         ST_PAYLOAD: begin
            tx_ready = 1'b1;
            raw_hs   = 1'b1;
            if (I_Tx_Valid) begin
               raw_byte    = I_Tx_Data;
               last_byte_d = I_Tx_Data;
               if (I_Tx_Last) begin
                  state_d = ST_TRAIL;
                  cnt_d   = TRAIL_INIT;
               end
            end else begin
               // Starved: close the packet early, this cycle is trailer byte 1.
               raw_byte    = trail_byte;
               underflow_d = 1'b1;
               if (TRAIL_LEN == 1) begin
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_TRAIL;
                  cnt_d   = TRAIL_UF_INIT;
               end
            end
         end

         ST_TRAIL: begin
            raw_byte = trail_byte;
            raw_hs   = 1'b1;
            if (cnt_q == 8'd0) state_d = ST_GAP;
            else               cnt_d   = cnt_q - 8'd1;
         end

         ST_GAP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign hs_en_d = raw_hs;
   assign busy_d  = (state_q != ST_IDLE);

   always_ff @(posedge I_CLK or posedge I_Rst) begin
      if (I_Rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         last_byte_q <= 8'h00;
         hs_en_q     <= 1'b0;
         underflow_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_byte_q <= last_byte_d;
         hs_en_q     <= hs_en_d;
         underflow_q <= underflow_d;
         busy_q      <= busy_d;
      end
   end

   mipi_bit_skew #(
      .BIT_SKEW (BIT_SKEW)
   ) u_bit_skew (
      .I_CLK  (I_CLK),
      .I_Rst  (I_Rst),
      .I_Data (raw_byte),
      .O_Data (O_Mipi_Byte_Data)
   );

   assign O_Tx_Ready   = tx_ready;
   assign O_Mipi_HS_En = hs_en_q;
   assign O_Busy       = busy_q;
   assign O_Underflow  = underflow_q;

endmodule : mipi_csi_byte_lane_tx
